puf_resp_ctrl: RTL and testbench



---
 rtl/puf_pkg.sv | 18 +
 rtl/puf_vote_cnt.sv | 25 ++
 rtl/puf_resp_ctrl.sv | 101 ++++++++++
 tb/tb_puf_resp_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// puf_pkg: FSM states, counter-width helper and default parameters shared by the PUF response controller.
package puf_pkg;
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_SAMPLE = 3'd2,
      ST_RELAX  = 3'd3,
      ST_DONE   = 3'd4
   } puf_state_e;
   localparam int DEF_WIDTH  = 8;
   localparam int DEF_CHAL_W = 2;
   localparam int DEF_VOTES  = 5;
   localparam int DEF_SETTLE = 4;
   localparam int DEF_RELAX  = 2;
   function automatic int cnt_w(input int max_val);
      return $clog2(max_val + 1);
   endfunction
endpackage

// File: rtl/puf_vote_cnt.sv
// puf_vote_cnt: per-bit vote counter; majority/unstable are derived from the post-increment count
// so the controller can register them on the same edge as the final sample.
module puf_vote_cnt
   import puf_pkg::*;
#(
   parameter int VOTES = DEF_VOTES
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_maj,
   output logic o_unst
);
   localparam int CW = cnt_w(VOTES);
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_nxt;
   assign w_nxt  = r_cnt + CW'(i_inc);
   assign o_maj  = w_nxt > CW'(VOTES / 2);
   assign o_unst = (w_nxt != '0) && (w_nxt != CW'(VOTES));
   always_ff @(posedge clk) begin
      if (rst || i_clr) r_cnt <= '0;
      else              r_cnt <= w_nxt;
   end
endmodule

// File: rtl/puf_resp_ctrl.sv
// puf_resp_ctrl: sequences settle/sample/relax over a PUF cell array and returns a
// majority-voted response with a per-bit instability mask over valid/ready.
module puf_resp_ctrl
   import puf_pkg::*;
#(
   parameter int WIDTH         = DEF_WIDTH,
   parameter int CHAL_W        = DEF_CHAL_W,
   parameter int VOTES         = DEF_VOTES,
   parameter int SETTLE_CYCLES = DEF_SETTLE,
   parameter int RELAX_CYCLES  = DEF_RELAX
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CHAL_W-1:0] challenge,
   output logic              busy,
   output logic              cell_enable,
   output logic [CHAL_W-1:0] cell_challenge,
   input  logic [WIDTH-1:0]  cell_bits,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [WIDTH-1:0]  response,
   output logic [WIDTH-1:0]  unstable_mask
);
   localparam int CW   = cnt_w(VOTES);
   localparam int TMAX = (SETTLE_CYCLES > RELAX_CYCLES) ? SETTLE_CYCLES : RELAX_CYCLES;
   localparam int TW   = cnt_w(TMAX);

   if (VOTES < 1 || (VOTES % 2) == 0 || SETTLE_CYCLES < 1 || RELAX_CYCLES < 1) begin : g_bad_params
      $error("puf_resp_ctrl: VOTES must be odd and >=1, SETTLE_CYCLES and RELAX_CYCLES >=1");
   end

   puf_state_e        r_state;
   logic [TW-1:0]     r_tmr;
   logic [CW-1:0]     r_smp;
   logic [CHAL_W-1:0] r_chal;
   logic [WIDTH-1:0]  r_resp;
   logic [WIDTH-1:0]  r_mask;
   logic [WIDTH-1:0]  w_maj;
   logic [WIDTH-1:0]  w_unst;
   logic              w_go;
   logic              w_smp;
   logic              w_last;
   logic              w_tdone;

   assign w_go    = (r_state == ST_IDLE) && start;
   assign w_smp   = (r_state == ST_SAMPLE);
   assign w_last  = w_smp && (r_smp == CW'(VOTES - 1));
   assign w_tdone = r_tmr == ((r_state == ST_SETTLE) ? TW'(SETTLE_CYCLES - 1) : TW'(RELAX_CYCLES - 1));

   assign busy           = (r_state != ST_IDLE);
   assign cell_enable    = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
   assign resp_valid     = (r_state == ST_DONE);
   assign cell_challenge = r_chal;
   assign response       = r_resp;
   assign unstable_mask  = r_mask;

   for (genvar i = 0; i < WIDTH; i++) begin : g_vote
      puf_vote_cnt #(.VOTES(VOTES)) u_vote (
         .clk    (clk),
         .rst    (rst),
         .i_clr  (w_go),
         .i_inc  (w_smp && cell_bits[i]),
         .o_maj  (w_maj[i]),
         .o_unst (w_unst[i])
      );
   end

   // One timer shared by SETTLE and RELAX; it idles at zero in every other state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_tmr   <= '0;
         r_smp   <= '0;
         r_chal  <= '0;
         r_resp  <= '0;
         r_mask  <= '0;
      end else begin
         r_tmr <= ((r_state == ST_SETTLE || r_state == ST_RELAX) && !w_tdone) ? r_tmr + 1'b1 : '0;
         case (r_state)
            ST_IDLE: if (start) begin
               r_state <= ST_SETTLE;
               r_chal  <= challenge;
               r_smp   <= '0;
            end
            ST_SETTLE: if (w_tdone) r_state <= ST_SAMPLE;
            ST_SAMPLE: begin
               r_smp   <= r_smp + 1'b1;
               r_state <= w_last ? ST_DONE : ST_RELAX;
            end
            ST_RELAX: if (w_tdone) r_state <= ST_SETTLE;
            ST_DONE:  if (resp_ready) r_state <= ST_IDLE;
            default:  r_state <= ST_IDLE;
         endcase
         if (w_last) begin
            r_resp <= w_maj;
            r_mask <= w_unst;
         end
      end
   end
endmodule

// File: tb/tb_puf_resp_ctrl.sv
// tb_puf_resp_ctrl: table-driven and randomized checks of puf_resp_ctrl against a vote-counting model.
module tb_puf_resp_ctrl;
   localparam int W   = 8;
   localparam int CH  = 2;
   localparam int V   = 5;
   localparam int S   = 4;
   localparam int R   = 2;
   localparam int P   = S + 1 + R;
   localparam int LAT = 1 + V * (S + 1) + (V - 1) * R;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, start, resp_ready, busy, cell_enable, resp_valid;
   logic [CH-1:0] challenge, cell_challenge;
   logic [W-1:0]  cell_bits, response, unstable_mask;
   logic          start1, resp_ready1, busy1, cell_enable1, resp_valid1;
   logic [CH-1:0] challenge1, cell_challenge1;
   logic [W-1:0]  cell_bits1, response1, unstable_mask1;

   puf_resp_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .challenge(challenge), .busy(busy),
      .cell_enable(cell_enable), .cell_challenge(cell_challenge), .cell_bits(cell_bits),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .response(response),
      .unstable_mask(unstable_mask)
   );

   puf_resp_ctrl #(.VOTES(1), .SETTLE_CYCLES(1), .RELAX_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .challenge(challenge1), .busy(busy1),
      .cell_enable(cell_enable1), .cell_challenge(cell_challenge1), .cell_bits(cell_bits1),
      .resp_valid(resp_valid1), .resp_ready(resp_ready1), .response(response1),
      .unstable_mask(unstable_mask1)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   function automatic logic [2*W-1:0] model(input logic [V-1:0][W-1:0] s);
      logic [W-1:0] rs, mk;
      for (int b = 0; b < W; b++) begin
         int cnt = 0;
         for (int k = 0; k < V; k++) cnt += int'(s[k][b]);
         rs[b] = cnt > V / 2;
         mk[b] = (cnt != 0) && (cnt != V);
      end
      return {rs, mk};
   endfunction

   task automatic run_req(input logic [V-1:0][W-1:0] s, input logic [CH-1:0] ch, input bit noise,
                          input int hold, input logic [W-1:0] er, input logic [W-1:0] em, input string nm);
      int c;
      bit seq_ok, hold_ok;
      @(negedge clk);
      start = 1'b1; challenge = ch; resp_ready = 1'b0; cell_bits = W'($urandom);
      c = 0; seq_ok = 1'b1;
      while (!resp_valid && c < 200) begin
         @(negedge clk);
         c++;
         if (!resp_valid) begin
            if (cell_enable !== (((c - 1) % P) <= S) || busy !== 1'b1 || cell_challenge !== ch) seq_ok = 1'b0;
            start     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            challenge = CH'($urandom);
            cell_bits = (((c - 1) % P) == S && (c - 1) / P < V) ? s[(c - 1) / P] : W'($urandom);
         end
      end
      start = 1'b0;
      chk({nm, " latency"}, c, LAT);
      chk({nm, " seq"}, 32'(seq_ok), 1);
      chk({nm, " response"}, 32'(response), 32'(er));
      chk({nm, " mask"}, 32'(unstable_mask), 32'(em));
      chk({nm, " chal_done"}, 32'(cell_challenge), 32'(ch));
      hold_ok = 1'b1;
      repeat (hold) begin
         @(negedge clk);
         cell_bits = W'($urandom);
         if (resp_valid !== 1'b1 || response !== er || unstable_mask !== em) hold_ok = 1'b0;
      end
      chk({nm, " hold"}, 32'(hold_ok), 1);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk({nm, " idle_busy"}, 32'(busy), 0);
      chk({nm, " idle_valid"}, 32'(resp_valid), 0);
      chk({nm, " idle_resp"}, 32'(response), 32'(er));
   endtask

   typedef struct {
      logic [V-1:0][W-1:0] s;
      logic [CH-1:0]       ch;
      bit                  noise;
      int                  hold;
      logic [W-1:0]        er;
      logic [W-1:0]        em;
   } vec_t;

   vec_t tbl[5];

   initial begin
      logic [V-1:0][W-1:0] rs;
      logic [2*W-1:0]      m;
      int                  c;
      tbl[0] = '{s: {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, ch: 2'b10, noise: 0, hold: 0,  er: 8'hFF, em: 8'h00};
      tbl[1] = '{s: {8'h5A, 8'hA5, 8'h5A, 8'hA5, 8'hA5}, ch: 2'b01, noise: 0, hold: 0,  er: 8'hA5, em: 8'hFF};
      tbl[2] = '{s: {8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01}, ch: 2'b11, noise: 1, hold: 0,  er: 8'h07, em: 8'h1E};
      tbl[3] = '{s: {8'hFF, 8'hF0, 8'hF0, 8'h0F, 8'h0F}, ch: 2'b00, noise: 0, hold: 10, er: 8'hFF, em: 8'hFF};
      tbl[4] = '{s: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, ch: 2'b10, noise: 1, hold: 3,  er: 8'h00, em: 8'h00};

      rst = 1'b1; start = 1'b0; challenge = '0; resp_ready = 1'b0; cell_bits = '0;
      start1 = 1'b0; challenge1 = '0; resp_ready1 = 1'b0; cell_bits1 = '0;
      repeat (3) @(negedge clk);
      chk("rst busy", 32'(busy), 0);
      chk("rst enable", 32'(cell_enable), 0);
      chk("rst valid", 32'(resp_valid), 0);
      chk("rst response", 32'(response), 0);
      chk("rst mask", 32'(unstable_mask), 0);
      chk("rst chal", 32'(cell_challenge), 0);
      rst = 1'b0;

      for (int i = 0; i < 5; i++)
         run_req(tbl[i].s, tbl[i].ch, tbl[i].noise, tbl[i].hold, tbl[i].er, tbl[i].em, $sformatf("vec%0d", i));

      for (int i = 0; i < 6; i++) begin
         for (int k = 0; k < V; k++) rs[k] = W'($urandom);
         m = model(rs);
         run_req(rs, CH'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 4),
                 m[2*W-1:W], m[W-1:0], $sformatf("rnd%0d", i));
      end

      // Abort in the relax window after the third sample.
      @(negedge clk);
      start = 1'b1; challenge = 2'b11; cell_bits = 8'hFF;
      c = 0;
      while (c < 2 * P + S + 2) begin
         @(negedge clk);
         c++;
         start = 1'b0;
      end
      chk("abort in_relax", 32'(cell_enable), 0);
      chk("abort busy_pre", 32'(busy), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort busy", 32'(busy), 0);
      chk("abort enable", 32'(cell_enable), 0);
      chk("abort valid", 32'(resp_valid), 0);
      chk("abort response", 32'(response), 0);
      chk("abort mask", 32'(unstable_mask), 0);
      chk("abort chal", 32'(cell_challenge), 0);
      run_req({8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01}, 2'b01, 0, 2, 8'h07, 8'h1E, "post_abort");

      @(negedge clk);
      start1 = 1'b1; challenge1 = 2'b01; cell_bits1 = 8'h3C;
      c = 0;
      while (!resp_valid1 && c < 50) begin
         @(negedge clk);
         c++;
         start1 = 1'b0;
      end
      chk("v1 latency", c, 3);
      chk("v1 response", 32'(response1), 32'h3C);
      chk("v1 mask", 32'(unstable_mask1), 0);
      chk("v1 chal", 32'(cell_challenge1), 1);
      resp_ready1 = 1'b1;
      @(negedge clk);
      resp_ready1 = 1'b0;
      chk("v1 idle", 32'(busy1), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
